collatz_sweep: RTL and testbench



---
 rtl/collatz_pkg.sv | 25 ++
 rtl/collatz_stepper.sv | 61 ++++++
 rtl/collatz_sweep.sv | 139 +++++++++++++
 tb/tb_collatz_sweep.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/collatz_pkg.sv
// Shared types for the Collatz range sweeper: FSM state encoding and the result record.
// COLLATZ_PEAK_EN adds the per-start-value trajectory peak to the result record.
package collatz_pkg;

    localparam int DATA_W = 8;
    localparam int STEP_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        EMIT,
        FIN
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] value;
        logic [STEP_W-1:0] steps;
        logic              ovf;
`ifdef COLLATZ_PEAK_EN
        logic [DATA_W-1:0] peak;
`endif
    } result_t;

endpackage

// File: rtl/collatz_stepper.sv
// Single-value Collatz engine: loads a seed, then takes one n/2 or 3n+1 step per enabled clock.
// COLLATZ_PEAK_EN adds a running maximum of the trajectory values.
module collatz_stepper
    import collatz_pkg::*;
#(
    parameter int W = DATA_W,
    parameter int S = STEP_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] seed,
    input  logic         run,
    output logic [W-1:0] cur,
    output logic [S-1:0] steps,
    output logic         finished,
    output logic         ovf
`ifdef COLLATZ_PEAK_EN
    ,
    output logic [W-1:0] peak
`endif
);

    logic [W+1:0] triple;
    logic [W-1:0] next_val;
    logic         step_ovf;
    logic         sat;

    // 3n+1 is formed two bits wider so an out-of-range result is detectable.
    assign triple   = {2'b00, cur} + {1'b0, cur, 1'b0} + (W+2)'(1);
    assign next_val = cur[0] ? triple[W-1:0] : (cur >> 1);
    assign step_ovf = cur[0] && (triple[W+1:W] != 2'b00);
    assign sat      = (steps == '1);
    assign finished = (cur == W'(1));
    assign ovf      = !finished && (step_ovf || sat);

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur   <= '0;
            steps <= '0;
`ifdef COLLATZ_PEAK_EN
            peak  <= '0;
`endif
        end else if (load) begin
            cur   <= seed;
            steps <= '0;
`ifdef COLLATZ_PEAK_EN
            peak  <= seed;
`endif
        end else if (run && !finished && !ovf) begin
            cur   <= next_val;
            steps <= steps + 1'b1;
`ifdef COLLATZ_PEAK_EN
            if (next_val > peak) peak <= next_val;
`endif
        end
    end

endmodule

// File: rtl/collatz_sweep.sv
// Sweeps start values over [range_lo, range_hi], streams one result per value and tracks the longest trajectory.
// COLLATZ_PEAK_EN adds the res_peak output (largest in-range trajectory value per start value).
module collatz_sweep
    import collatz_pkg::*;
#(
    parameter int W = DATA_W,
    parameter int S = STEP_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] range_lo,
    input  logic [W-1:0] range_hi,
    output logic         busy,
    output logic         done,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_value,
    output logic [S-1:0] res_steps,
    output logic         res_ovf,
`ifdef COLLATZ_PEAK_EN
    output logic [W-1:0] res_peak,
`endif
    output logic [W-1:0] max_value,
    output logic [S-1:0] max_steps
);

    state_t       state, state_next;
    logic [W-1:0] idx, hi;
    result_t      res;
    logic         max_seen;
    logic         step_load, step_run;
    logic [W-1:0] step_cur;
    logic [S-1:0] step_count;
    logic         step_finished, step_ovf;
`ifdef COLLATZ_PEAK_EN
    logic [W-1:0] step_peak;
`endif

    collatz_stepper #(.W(W), .S(S)) u_stepper (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (step_load),
        .seed     (idx),
        .run      (step_run),
        .cur      (step_cur),
        .steps    (step_count),
        .finished (step_finished),
        .ovf      (step_ovf)
`ifdef COLLATZ_PEAK_EN
        ,
        .peak     (step_peak)
`endif
    );

    // NOTE: every always_comb output gets a default before the case so no
    // path leaves a signal unassigned and a latch is never inferred.
    always_comb begin
        state_next = state;
        step_load  = 1'b0;
        step_run   = 1'b0;
        case (state)
            IDLE: if (start) state_next = (range_lo > range_hi) ? FIN : LOAD;
            LOAD: begin
                step_load  = 1'b1;
                state_next = (idx == '0) ? EMIT : RUN;
            end
            RUN: begin
                step_run = 1'b1;
                if (step_finished || step_ovf) state_next = EMIT;
            end
            EMIT: if (res_ready) state_next = (idx == hi) ? FIN : LOAD;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            hi        <= '0;
            res       <= '0;
            max_value <= '0;
            max_steps <= '0;
            max_seen  <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: if (start) begin
                    idx       <= range_lo;
                    hi        <= range_hi;
                    max_value <= '0;
                    max_steps <= '0;
                    max_seen  <= 1'b0;
                end
                LOAD: if (idx == '0) begin
                    res.value <= idx;
                    res.steps <= '0;
                    res.ovf   <= 1'b1;
`ifdef COLLATZ_PEAK_EN
                    res.peak  <= '0;
`endif
                end
                RUN: if (step_finished || step_ovf) begin
                    res.value <= idx;
                    res.steps <= step_count;
                    res.ovf   <= !step_finished;
`ifdef COLLATZ_PEAK_EN
                    res.peak  <= step_peak;
`endif
                end
                EMIT: if (res_ready) begin
                    // Strict compare keeps the earlier value on ties; the first clean result always seeds the tracker.
                    if (!res.ovf && (!max_seen || res.steps > max_steps)) begin
                        max_value <= res.value;
                        max_steps <= res.steps;
                        max_seen  <= 1'b1;
                    end
                    if (idx != hi) idx <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // busy covers the accepting cycle as well, so an empty range still shows one busy cycle.
    assign busy      = (state == LOAD) || (state == RUN) || (state == EMIT)
                     || ((state == IDLE) && start && rst_n);
    assign done      = (state == FIN);
    assign res_valid = (state == EMIT);
    assign res_value = res.value;
    assign res_steps = res.steps;
    assign res_ovf   = res.ovf;
`ifdef COLLATZ_PEAK_EN
    assign res_peak  = res.peak;
`endif

endmodule

// File: tb/tb_collatz_sweep.sv
// Directed self-checking bench for collatz_sweep (W=8, S=8); expected values are hand-computed trajectories.
// COLLATZ_PEAK_EN enables the res_peak comparisons.
module tb_collatz_sweep;

    localparam int W = 8;
    localparam int S = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] range_lo = '0;
    logic [W-1:0] range_hi = '0;
    logic         res_ready = 1'b1;
    logic         busy, done, res_valid, res_ovf;
    logic [W-1:0] res_value, max_value;
    logic [S-1:0] res_steps, max_steps;
`ifdef COLLATZ_PEAK_EN
    logic [W-1:0] res_peak;
`endif

    int passed = 0;
    int total  = 0;

    collatz_sweep #(.W(W), .S(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .range_lo  (range_lo),
        .range_hi  (range_hi),
        .busy      (busy),
        .done      (done),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_value (res_value),
        .res_steps (res_steps),
        .res_ovf   (res_ovf),
`ifdef COLLATZ_PEAK_EN
        .res_peak  (res_peak),
`endif
        .max_value (max_value),
        .max_steps (max_steps)
    );

    always #5 clk = ~clk;

    task automatic pulse_start(input logic [W-1:0] lo, input logic [W-1:0] hi);
        @(negedge clk);
        range_lo = lo;
        range_hi = hi;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_valid(output int cycles, output bit ok);
        cycles = 0;
        while (!res_valid && cycles < 300) begin
            @(negedge clk);
            cycles++;
        end
        ok = res_valid;
    endtask

    task automatic wait_done(output int cycles, output bit ok);
        cycles = 0;
        while (!done && cycles < 300) begin
            @(negedge clk);
            cycles++;
        end
        ok = done;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({busy, done, res_valid, res_value, res_steps, res_ovf, max_value, max_steps} !== '0)
            $display("FAIL reset_outputs: got busy=%b done=%b valid=%b val=%0d steps=%0d ovf=%b max=%0d/%0d, want all 0",
                     busy, done, res_valid, res_value, res_steps, res_ovf, max_value, max_steps);
        else passed++;
        rst_n = 1'b1;
    endtask

    task automatic test_range_6_7();
        int c; bit ok;
        res_ready = 1'b1;
        pulse_start(8'd6, 8'd7);
        wait_valid(c, ok);
        total++;
        if (!ok || c !== 10) $display("FAIL lat_6: got valid=%b after %0d cycles, want 10", ok, c);
        else passed++;
        total++;
        if ({res_value, res_steps, res_ovf} !== {8'd6, 8'd8, 1'b0})
            $display("FAIL res_6: got (%0d,%0d,%b), want (6,8,0)", res_value, res_steps, res_ovf);
        else passed++;
`ifdef COLLATZ_PEAK_EN
        total++;
        if (res_peak !== 8'd16) $display("FAIL peak_6: got %0d, want 16", res_peak);
        else passed++;
`endif
        @(negedge clk);
        wait_valid(c, ok);
        total++;
        if (!ok || {res_value, res_steps, res_ovf} !== {8'd7, 8'd16, 1'b0})
            $display("FAIL res_7: got valid=%b (%0d,%0d,%b), want (7,16,0)", ok, res_value, res_steps, res_ovf);
        else passed++;
`ifdef COLLATZ_PEAK_EN
        total++;
        if (res_peak !== 8'd52) $display("FAIL peak_7: got %0d, want 52", res_peak);
        else passed++;
`endif
        wait_done(c, ok);
        total++;
        if (!ok || c !== 1 || busy !== 1'b0)
            $display("FAIL done_6_7: got done=%b after %0d cycles busy=%b, want done after 1, busy 0", ok, c, busy);
        else passed++;
        @(negedge clk);
        total++;
        if (done !== 1'b0) $display("FAIL done_once_6_7: got done=%b one cycle later, want 0", done);
        else passed++;
        total++;
        if ({max_value, max_steps} !== {8'd7, 8'd16})
            $display("FAIL max_6_7: got %0d/%0d, want 7/16", max_value, max_steps);
        else passed++;
    endtask

    task automatic test_range_0_1();
        int c; bit ok;
        pulse_start(8'd0, 8'd1);
        wait_valid(c, ok);
        total++;
        if (!ok || c !== 1 || {res_value, res_steps, res_ovf} !== {8'd0, 8'd0, 1'b1})
            $display("FAIL res_0: got valid=%b lat=%0d (%0d,%0d,%b), want lat 1 (0,0,1)", ok, c, res_value, res_steps, res_ovf);
        else passed++;
        @(negedge clk);
        wait_valid(c, ok);
        total++;
        if (!ok || {res_value, res_steps, res_ovf} !== {8'd1, 8'd0, 1'b0})
            $display("FAIL res_1: got valid=%b (%0d,%0d,%b), want (1,0,0)", ok, res_value, res_steps, res_ovf);
        else passed++;
        wait_done(c, ok);
        total++;
        if (!ok || {max_value, max_steps} !== {8'd1, 8'd0})
            $display("FAIL max_0_1: got done=%b max %0d/%0d, want 1/0", ok, max_value, max_steps);
        else passed++;
    endtask

    task automatic test_ovf_255();
        int c; bit ok;
        pulse_start(8'd255, 8'd255);
        wait_valid(c, ok);
        total++;
        if (!ok || c !== 2 || {res_value, res_steps, res_ovf} !== {8'd255, 8'd0, 1'b1})
            $display("FAIL res_255: got valid=%b lat=%0d (%0d,%0d,%b), want lat 2 (255,0,1)", ok, c, res_value, res_steps, res_ovf);
        else passed++;
`ifdef COLLATZ_PEAK_EN
        total++;
        if (res_peak !== 8'd255) $display("FAIL peak_255: got %0d, want 255", res_peak);
        else passed++;
`endif
        wait_done(c, ok);
        total++;
        if (!ok || {max_value, max_steps} !== 16'd0)
            $display("FAIL done_255: got done=%b max %0d/%0d, want done, 0/0", ok, max_value, max_steps);
        else passed++;
    endtask

    task automatic test_empty_range();
        @(negedge clk);
        range_lo = 8'd3;
        range_hi = 8'd2;
        start    = 1'b1;
        #1;
        total++;
        if (busy !== 1'b1) $display("FAIL empty_busy: got busy=%b on start cycle, want 1", busy);
        else passed++;
        @(negedge clk);
        start = 1'b0;
        total++;
        if ({done, busy, res_valid} !== 3'b100)
            $display("FAIL empty_done: got done=%b busy=%b valid=%b, want 1 0 0", done, busy, res_valid);
        else passed++;
        @(negedge clk);
        total++;
        if ({done, busy, res_valid} !== 3'b000)
            $display("FAIL empty_after: got done=%b busy=%b valid=%b, want 0 0 0", done, busy, res_valid);
        else passed++;
    endtask

    task automatic test_backpressure();
        int c; bit ok; bit held;
        res_ready = 1'b0;
        pulse_start(8'd6, 8'd7);
        wait_valid(c, ok);
        held = ok;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start    = 1'b1;
                range_lo = 8'd3;
                range_hi = 8'd3;
            end
            if (i == 2) start = 1'b0;
            if (!res_valid || res_value !== 8'd6 || res_steps !== 8'd8 || busy !== 1'b1) held = 1'b0;
        end
        total++;
        if (!held) $display("FAIL bp_hold: got valid=%b (%0d,%0d) busy=%b, want 6/8 held", res_valid, res_value, res_steps, busy);
        else passed++;
        res_ready = 1'b1;
        @(negedge clk);
        total++;
        if (res_valid !== 1'b0) $display("FAIL bp_release: got valid=%b after handshake, want 0", res_valid);
        else passed++;
        wait_valid(c, ok);
        total++;
        if (!ok || {res_value, res_steps} !== {8'd7, 8'd16})
            $display("FAIL bp_second: got valid=%b (%0d,%0d), want (7,16)", ok, res_value, res_steps);
        else passed++;
        wait_done(c, ok);
        total++;
        if (!ok || {max_value, max_steps} !== {8'd7, 8'd16})
            $display("FAIL bp_max: got done=%b max %0d/%0d, want 7/16", ok, max_value, max_steps);
        else passed++;
    endtask

    task automatic test_reset_mid_sweep();
        int c; bit ok; bit quiet;
        pulse_start(8'd7, 8'd7);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        total++;
        if ({busy, done, res_valid, res_value, res_steps, res_ovf, max_value, max_steps} !== '0)
            $display("FAIL mid_reset: got busy=%b done=%b valid=%b val=%0d steps=%0d ovf=%b max=%0d/%0d, want all 0",
                     busy, done, res_valid, res_value, res_steps, res_ovf, max_value, max_steps);
        else passed++;
        quiet = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (done || res_valid || busy) quiet = 1'b0;
        end
        total++;
        if (!quiet) $display("FAIL mid_reset_quiet: got activity after reset, want idle");
        else passed++;
        pulse_start(8'd6, 8'd6);
        wait_valid(c, ok);
        total++;
        if (!ok || {res_value, res_steps, res_ovf} !== {8'd6, 8'd8, 1'b0})
            $display("FAIL restart_6: got valid=%b (%0d,%0d,%b), want (6,8,0)", ok, res_value, res_steps, res_ovf);
        else passed++;
        wait_done(c, ok);
        total++;
        if (!ok) $display("FAIL restart_done: got no done within bound, want done");
        else passed++;
    endtask

    initial begin
        test_reset();
        test_range_6_7();
        test_range_0_1();
        test_ovf_255();
        test_empty_range();
        test_backpressure();
        test_reset_mid_sweep();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
